// File: rtl/sha256_msg_sched_if.sv
// Block-load and schedule-word streaming signals between the padding stage,
// the message scheduler and the compression round stage.
interface sha256_msg_sched_if;
  logic         start;
  logic [511:0] block_in;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   t_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, block_in, w_ready,
    input  w_valid, w_out, t_idx, busy, done
  );

  modport slave (
    input  start, block_in, w_ready,
    output w_valid, w_out, t_idx, busy, done
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule expander: a 16-word sliding window streams
// W0..W(ROUNDS-1) one word per accepted handshake.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  sha256_msg_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] load_word [16];
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic        xfer;
  logic [31:0] new_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // W0 sits in the most significant word of the padded block.
  for (genvar gi = 0; gi < 16; gi++) begin : g_load
    assign load_word[gi] = bus.block_in[511 - 32*gi -: 32];
  end

  assign xfer     = (state_q == RUN) && bus.w_ready;
  assign new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      win_d[k] = win_q[k];
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int k = 0; k < 16; k++) begin
            win_d[k] = load_word[k];
          end
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          for (int k = 0; k < 15; k++) begin
            win_d[k] = win_q[k+1];
          end
          // Words generated beyond the last emitted index are simply never shown.
          win_d[15] = new_word;
          if (t_q == LAST_T) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int k = 0; k < 16; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  // All outputs come straight from registers, so w_ready/start never reach w_valid.
  assign bus.w_valid = (state_q == RUN);
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.w_out   = win_q[0];
  assign bus.t_idx   = t_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: golden schedule model plus
// hand-computed "abc" words, stalls, ignored start, chaining and abort.
module tb_sha256_msg_sched;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_w [64];

  sha256_msg_sched_if bus_if ();

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) begin
      exp_w[t] = b[511 - 32*t -: 32];
    end
    for (int t = 16; t < 64; t++) begin
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  // mode: 0 ready always, 1 random ready, 2 ten-cycle stall at t=16,
  //       3 ready always plus a stray start with another block at t=5
  task automatic run_block(input logic [511:0] blk, input int mode, input bit preloaded,
                           input bit chain, input logic [511:0] next_blk,
                           input int abort_at, input bit is_abc);
    int t;
    int cyc;
    int stall_n;
    bit rdy;
    build_model(blk);
    if (!preloaded) begin
      @(negedge clk);
      bus_if.start    = 1'b1;
      bus_if.block_in = blk;
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    t = 0;
    cyc = 0;
    stall_n = 0;
    while (t < 64) begin
      check("ctl_run", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b110));
      check("t_idx", 64'(bus_if.t_idx), 64'(t));
      check("w_out", 64'(bus_if.w_out), 64'(exp_w[t]));
      if (is_abc) begin
        case (t)
          0:  check("abc_W0",  64'(bus_if.w_out), 64'h61626380);
          15: check("abc_W15", 64'(bus_if.w_out), 64'h00000018);
          16: check("abc_W16", 64'(bus_if.w_out), 64'h61626380);
          17: check("abc_W17", 64'(bus_if.w_out), 64'h000F0000);
          18: check("abc_W18", 64'(bus_if.w_out), 64'h7DA86405);
          19: check("abc_W19", 64'(bus_if.w_out), 64'h600003C6);
          20: check("abc_W20", 64'(bus_if.w_out), 64'h3E9D7B78);
          default: ;
        endcase
      end
      if (t == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_ctl", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b000));
        check("abort_t_idx", 64'(bus_if.t_idx), 64'd0);
        check("abort_w_out", 64'(bus_if.w_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.w_ready = 1'b0;
        @(negedge clk);
        check("abort_no_done", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b000));
        return;
      end
      case (mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(t == 16 && stall_n < 10);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall_n++;
      if (mode == 3 && t == 5) begin
        bus_if.start    = 1'b1;
        bus_if.block_in = ~blk;
      end
      bus_if.w_ready = rdy;
      @(negedge clk);
      bus_if.start = 1'b0;
      if (rdy) t++;
      cyc++;
      if (cyc > 1000) begin
        check("timeout", 64'(cyc), 64'd0);
        bus_if.w_ready = 1'b0;
        return;
      end
    end
    bus_if.w_ready = 1'b0;
    check("done_cycle", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b001));
    check("t_idx_wrap", 64'(bus_if.t_idx), 64'd0);
    if (mode == 2) check("stall_cycles", 64'(stall_n), 64'd10);
    if (chain) begin
      bus_if.start    = 1'b1;
      bus_if.block_in = next_blk;
    end else begin
      @(negedge clk);
      check("done_once", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b000));
    end
  endtask

  initial begin
    logic [511:0] blk_abc;
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    logic [511:0] blk_c;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.block_in = '0;
    bus_if.w_ready  = 1'b0;

    blk_abc = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[31:0]    = 32'h00000018;
    for (int k = 0; k < 16; k++) begin
      blk_a[511 - 32*k -: 32] = 32'h9E3779B9 * (k + 1);
      blk_b[511 - 32*k -: 32] = 32'h01234567 ^ (32'h11111111 * k);
      blk_c[511 - 32*k -: 32] = 32'hDEADBEEF + (32'h00010001 * k);
    end

    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b000));
    check("rst_t_idx", 64'(bus_if.t_idx), 64'd0);
    check("rst_w_out", 64'(bus_if.w_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ctl", 64'({bus_if.w_valid, bus_if.busy, bus_if.done}), 64'(3'b000));

    run_block(blk_abc, 0, 1'b0, 1'b0, '0, -1, 1'b1);
    run_block('0, 1, 1'b0, 1'b0, '0, -1, 1'b0);
    run_block({16{32'hFFFFFFFF}}, 2, 1'b0, 1'b0, '0, -1, 1'b0);
    run_block(blk_a, 3, 1'b0, 1'b0, '0, -1, 1'b0);
    run_block(blk_b, 0, 1'b0, 1'b1, blk_c, -1, 1'b0);
    run_block(blk_c, 0, 1'b1, 1'b0, '0, -1, 1'b0);
    run_block(blk_a, 0, 1'b0, 1'b0, '0, 30, 1'b0);
    run_block(blk_abc, 1, 1'b0, 1'b0, '0, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
